audio_rd_sched: RTL and testbench
=================================

# audio_rd_sched

Audio read scheduler in the HDMI receive path, clocked by the 74.25 MHz pixel clock. It sits between the receive audio FIFO (12-bit afifo12, written from the GMII 125 MHz side) and the TMDS audio-island encoder. During horizontal blanking it drains the FIFO in fixed 32-word bursts and uses the per-word burst tag to decide whether another burst follows on the same line. It also reports once per frame whether any audio arrived.

## Interface
Parameters:
- BURST_LEN, 32: FIFO reads per burst.
- GAP_LEN, 4: idle cycles between consecutive bursts; burst period is BURST_LEN+GAP_LEN = 36.
- START_HCNT, 1530: horizontal count at which the first burst of a line is armed.
- MAX_BURSTS, 15: hard cap on bursts per line.

Ports (one clock; reset is asynchronous and active-low):
- i_clk_74M  in  1  pixel clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hcnt  in  12  horizontal counter from the timing generator.
- i_vcnt  in  12  vertical counter from the timing generator.
- i_vde  in  1  registered video data enable (active area).
- i_flush  in  1  synchronous clear, one-cycle pulse from the audio FIFO resync logic.
- i_empty  in  1  receive audio FIFO Empty.
- i_q  in  12  receive audio FIFO Q; [11:8] = bursts remaining after this one, [7:0] = payload.
- o_rd_en  out  1  FIFO RdEn.
- o_valid  out  1  o_data holds a word read on the previous cycle.
- o_data  out  12  registered copy of i_q.
- o_burst_cnt  out  4  bursts completed on the current line.
- o_audio_on  out  1  audio seen during the previous frame.
- o_underrun  out  1  one-cycle pulse: FIFO went empty mid-burst.

## Operation
- States: IDLE, ARMED, READ, GAP.
- IDLE -> ARMED on the first cycle with i_vde=1 after reset or flush. The block never returns to IDLE except via reset or flush.
- ARMED -> READ when i_hcnt==START_HCNT and i_vde==0 and i_empty==0.
  - On this transition: burst counter cleared, beat counter cleared.
- READ: o_rd_en=1 while beat<BURST_LEN and i_empty==0. Beat counter increments on each read.
  - After BURST_LEN reads: -> GAP, o_burst_cnt += 1.
  - If i_empty==1 while in READ: o_rd_en=0 in that same cycle (combinational gate on a registered request), o_underrun pulses next cycle, -> ARMED. The partial burst is not counted.
- GAP: GAP_LEN cycles with o_rd_en=0. On the last GAP cycle, evaluate the continue condition:
  - Continue = latched tag of the final burst word != 0, and i_empty==0, and o_burst_cnt<MAX_BURSTS.
  - If continue: -> READ. Otherwise -> ARMED.
- FIFO read latency is 1 cycle. o_valid = o_rd_en delayed by one cycle. o_data = i_q registered on the o_valid cycle. The tag is latched from the last word whose o_valid is asserted.
- Audio detect: a sticky flag is set whenever i_empty==0.
  - On the cycle with i_vcnt==0 and i_hcnt==0: o_audio_on <= flag, and flag <= ~i_empty. A sample on that exact cycle counts toward the new frame.
- i_flush: same effect as reset on all state and outputs, applied synchronously. It takes priority over every other event in the same cycle.
- o_burst_cnt saturates at 15 and has no wrap-around.

## Timing
- Reset values: o_rd_en=0, o_valid=0, o_data=0, o_burst_cnt=0, o_audio_on=0, o_underrun=0. State = IDLE.
- Reset and flush take effect immediately, including mid-burst. No partial read completes after either.
- From i_hcnt==START_HCNT, o_rd_en rises on the next cycle and stays high exactly 32 cycles. It is then low exactly 4 cycles. A continued burst starts on cycle 37 relative to the first rd_en.
- o_valid trails o_rd_en by exactly 1 cycle, with the same pulse count.
- Arming is evaluated only on the single START_HCNT cycle. If the FIFO is empty then, that line has no audio burst.
- o_audio_on changes only at i_vcnt==0, i_hcnt==0.

## Test plan
- Reset then first active line: FIFO holds 32 words with tag 0, i_hcnt reaches 1530 with i_vde=0 -> exactly 32 o_rd_en cycles, 32 o_valid, o_burst_cnt=1, no further reads that line.
- Three bursts with tags 2, 1, 0 (96 words) -> rd_en pattern 32 on / 4 off, repeated three times. o_burst_cnt steps 1, 2, 3 and stops.
- FIFO empties after 20 words of a burst -> o_rd_en drops in the same cycle, o_underrun pulses once, state ARMED, o_burst_cnt unchanged. Next line resumes normally.
- Assert i_rst_n=0 at beat 10 of a burst -> all outputs 0 immediately. After release, no reads until i_vde has been seen and the next START_HCNT.
- Audio presence: frame with data -> o_audio_on=1 at the next i_vcnt=0,i_hcnt=0. Frame with FIFO always empty -> o_audio_on=0 one frame later. Data arriving exactly on the frame-boundary cycle counts toward the new frame.
- Tag 15 on every burst -> reads stop after 15 bursts (o_burst_cnt=15, saturated).

Source files
------------

// File: rtl/audio_rd_sched.sv
// audio_rd_sched: drains the receive audio FIFO in fixed-length bursts during
// horizontal blanking and reports per-frame audio presence.
//
// Ports:
//   i_clk_74M    pixel clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_hcnt       horizontal counter
//   i_vcnt       vertical counter
//   i_vde        registered video data enable
//   i_flush      synchronous clear pulse, highest priority
//   i_empty      FIFO empty
//   i_q          FIFO data: [11:8] bursts remaining after this one, [7:0] payload
//   o_rd_en      FIFO read enable
//   o_valid      o_rd_en delayed by one cycle (FIFO word present on i_q)
//   o_data       registered copy of i_q, captured on the o_valid cycle
//   o_burst_cnt  bursts completed on the current line (saturating)
//   o_audio_on   audio seen during the previous frame
//   o_underrun   one-cycle pulse when the FIFO ran dry mid-burst
module audio_rd_sched #(
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned GAP_LEN    = 4,
    parameter int unsigned START_HCNT = 1530,
    parameter int unsigned MAX_BURSTS = 15
) (
    input  logic        i_clk_74M,
    input  logic        i_rst_n,
    input  logic [11:0] i_hcnt,
    input  logic [11:0] i_vcnt,
    input  logic        i_vde,
    input  logic        i_flush,
    input  logic        i_empty,
    input  logic [11:0] i_q,
    output logic        o_rd_en,
    output logic        o_valid,
    output logic [11:0] o_data,
    output logic [3:0]  o_burst_cnt,
    output logic        o_audio_on,
    output logic        o_underrun
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned GapW  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StRead, StGap} state_e;

    state_e             state_q, state_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [3:0]         burst_q, burst_d;
    logic [3:0]         tag_q;
    logic               valid_q;
    logic [11:0]        data_q;
    logic               underrun_q, underrun_d;
    logic               flag_q;
    logic               audio_on_q;
    logic               rd_en;
    logic               frame_start;

    assign frame_start = (i_vcnt == 12'd0) && (i_hcnt == 12'd0);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        burst_d    = burst_q;
        underrun_d = 1'b0;
        rd_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_vde) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Arming is sampled only on the single START_HCNT cycle.
                if ((i_hcnt == 12'(START_HCNT)) && !i_vde && !i_empty) begin
                    state_d = StRead;
                    beat_d  = '0;
                    burst_d = 4'd0;
                end
            end
            StRead: begin
                if (i_empty) begin
                    // Partial burst is abandoned and not counted.
                    state_d    = StArmed;
                    beat_d     = '0;
                    underrun_d = 1'b1;
                end else begin
                    rd_en = 1'b1;
                    if (beat_q == BeatW'(BURST_LEN - 1)) begin
                        beat_d  = '0;
                        gap_d   = '0;
                        state_d = StGap;
                        if (burst_q != 4'hF) begin
                            burst_d = burst_q + 4'd1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_LEN - 1)) begin
                    gap_d = '0;
                    // tag_q holds the remaining-bursts field of the last word of the burst.
                    if ((tag_q != 4'd0) && !i_empty && (burst_q < 4'(MAX_BURSTS))) begin
                        state_d = StRead;
                    end else begin
                        state_d = StArmed;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase

        // Flush must stop the read in the very cycle it is asserted.
        if (i_flush) begin
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            gap_q      <= '0;
            burst_q    <= 4'd0;
            tag_q      <= 4'd0;
            valid_q    <= 1'b0;
            data_q     <= 12'd0;
            underrun_q <= 1'b0;
            flag_q     <= 1'b0;
            audio_on_q <= 1'b0;
        end else if (i_flush) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            gap_q      <= '0;
            burst_q    <= 4'd0;
            tag_q      <= 4'd0;
            valid_q    <= 1'b0;
            data_q     <= 12'd0;
            underrun_q <= 1'b0;
            flag_q     <= 1'b0;
            audio_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            burst_q    <= burst_d;
            underrun_q <= underrun_d;
            valid_q    <= rd_en;
            if (valid_q) begin
                data_q <= i_q;
                tag_q  <= i_q[11:8];
            end
            // A sample on the boundary cycle belongs to the new frame.
            if (frame_start) begin
                audio_on_q <= flag_q;
                flag_q     <= ~i_empty;
            end else begin
                flag_q <= flag_q | ~i_empty;
            end
        end
    end

    assign o_rd_en     = rd_en;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_burst_cnt = burst_q;
    assign o_audio_on  = audio_on_q;
    assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_audio_rd_sched.sv
module tb_audio_rd_sched;

    localparam int H_TOTAL = 2100;
    localparam int H_ACT   = 1280;
    localparam int V_TOTAL = 2;
    localparam int V_ACT   = 1;
    localparam int START   = 1530;

    logic        i_clk_74M = 1'b0;
    logic        i_rst_n;
    logic [11:0] i_hcnt;
    logic [11:0] i_vcnt;
    logic        i_vde;
    logic        i_flush;
    logic        i_empty;
    logic [11:0] i_q;
    logic        o_rd_en;
    logic        o_valid;
    logic [11:0] o_data;
    logic [3:0]  o_burst_cnt;
    logic        o_audio_on;
    logic        o_underrun;

    always #5 i_clk_74M = ~i_clk_74M;

    audio_rd_sched dut (
        .i_clk_74M   (i_clk_74M),
        .i_rst_n     (i_rst_n),
        .i_hcnt      (i_hcnt),
        .i_vcnt      (i_vcnt),
        .i_vde       (i_vde),
        .i_flush     (i_flush),
        .i_empty     (i_empty),
        .i_q         (i_q),
        .o_rd_en     (o_rd_en),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_burst_cnt (o_burst_cnt),
        .o_audio_on  (o_audio_on),
        .o_underrun  (o_underrun)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [11:0] fifo[$];
    logic [11:0] sb[$];
    logic [11:0] q_word = 12'd0;
    logic [7:0]  payload = 8'd1;
    bit          rd_s = 1'b0;
    bit          valid_prev = 1'b0;
    bit          glitch = 1'b0;
    bit          vde_en = 1'b1;
    int          hc = H_TOTAL - 1;
    int          vc = V_TOTAL - 1;

    int          runs[$];
    int          gaps[$];
    int          rise_h[$];
    int          ur_h[$];
    logic [3:0]  bc_hist[$];
    logic [3:0]  bc_prev;
    int          off_len;
    int          vcount;
    int          rd_empty_cnt;
    int          ao_bad;
    logic        ao_prev;

    task automatic clear_rec();
        runs.delete();
        gaps.delete();
        rise_h.delete();
        ur_h.delete();
        bc_hist.delete();
        bc_prev = o_burst_cnt;
        off_len = 0;
        vcount = 0;
        rd_empty_cnt = 0;
        ao_bad = 0;
        ao_prev = o_audio_on;
    endtask

    task automatic push_burst(input logic [3:0] tag, input int n);
        for (int i = 0; i < n; i++) begin
            fifo.push_back({tag, payload});
            payload = payload + 8'd1;
        end
    endtask

    // One clock: FIFO model and timing generator update after the edge, outputs
    // are sampled and scoreboarded on the falling edge.
    task automatic cycle();
        logic        new_rd;
        logic [11:0] exp_w;
        @(posedge i_clk_74M);
        #1;
        i_flush = 1'b0;
        if (rd_s && fifo.size() > 0) begin
            q_word = fifo.pop_front();
            sb.push_back(q_word);
        end
        i_q = q_word;
        if (hc == H_TOTAL - 1) begin
            hc = 0;
            vc = (vc == V_TOTAL - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
        i_hcnt  = 12'(hc);
        i_vcnt  = 12'(vc);
        i_vde   = (vde_en && vc < V_ACT && hc < H_ACT) ? 1'b1 : 1'b0;
        i_empty = (fifo.size() == 0 && !glitch) ? 1'b1 : 1'b0;
        @(negedge i_clk_74M);
        total_cnt++;
        if (o_valid !== rd_s)
            $display("FAIL valid_align h=%0d v=%0d: got %0b expected %0b", hc, vc, o_valid, rd_s);
        else
            pass_cnt++;
        if (valid_prev) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL data_sb h=%0d: got %h expected none pending", hc, o_data);
            end else begin
                exp_w = sb.pop_front();
                if (o_data !== exp_w)
                    $display("FAIL data h=%0d: got %h expected %h", hc, o_data, exp_w);
                else
                    pass_cnt++;
            end
        end
        new_rd = o_rd_en;
        if (new_rd && i_empty) rd_empty_cnt++;
        if (new_rd) begin
            if (!rd_s) begin
                if (runs.size() > 0) gaps.push_back(off_len);
                runs.push_back(1);
                rise_h.push_back(hc);
            end else begin
                runs[runs.size()-1] = runs[runs.size()-1] + 1;
            end
            off_len = 0;
        end else begin
            off_len++;
        end
        rd_s = new_rd;
        valid_prev = o_valid;
        if (o_valid) vcount++;
        if (o_underrun) ur_h.push_back(hc);
        if (o_burst_cnt !== bc_prev) begin
            bc_hist.push_back(o_burst_cnt);
            bc_prev = o_burst_cnt;
        end
        if (o_audio_on !== ao_prev && !(hc == 1 && vc == 0)) ao_bad++;
        ao_prev = o_audio_on;
    endtask

    task automatic next_line();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (hc != 0 && n < H_TOTAL + 2);
        if (hc != 0) begin
            total_cnt++;
            $display("FAIL line_timeout: got h=%0d expected 0", hc);
        end
    endtask

    task automatic frame_edge();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(hc == 1 && vc == 0) && n < 2 * H_TOTAL * V_TOTAL);
        if (!(hc == 1 && vc == 0)) begin
            total_cnt++;
            $display("FAIL frame_timeout: got h=%0d v=%0d expected h=1 v=0", hc, vc);
        end
    endtask

    task automatic wait_run(input int len);
        int n = 0;
        while (!(runs.size() > 0 && runs[runs.size()-1] == len && rd_s) && n < 2 * H_TOTAL) begin
            cycle();
            n++;
        end
        if (n >= 2 * H_TOTAL) begin
            total_cnt++;
            $display("FAIL run_timeout: got no run of %0d expected one", len);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_hcnt  = 12'(hc);
        i_vcnt  = 12'(vc);
        i_vde   = 1'b0;
        i_empty = 1'b1;
        i_q     = 12'd0;
        #2;
        total_cnt++; if (o_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %0b expected 0", o_rd_en); else pass_cnt++;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", o_valid); else pass_cnt++;
        total_cnt++; if (o_data !== 12'd0) $display("FAIL rst_data: got %h expected 000", o_data); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd0) $display("FAIL rst_burst_cnt: got %0d expected 0", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL rst_audio_on: got %0b expected 0", o_audio_on); else pass_cnt++;
        total_cnt++; if (o_underrun !== 1'b0) $display("FAIL rst_underrun: got %0b expected 0", o_underrun); else pass_cnt++;
        @(negedge i_clk_74M);
        @(negedge i_clk_74M);
        i_rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_burst();
        clear_rec();
        push_burst(4'd0, 32);
        next_line();
        total_cnt++; if (runs.size() !== 1) $display("FAIL single_runs: got %0d expected 1", runs.size()); else pass_cnt++;
        total_cnt++; if (runs[0] !== 32) $display("FAIL single_len: got %0d expected 32", runs[0]); else pass_cnt++;
        total_cnt++; if (rise_h[0] !== START + 1) $display("FAIL single_rise: got %0d expected %0d", rise_h[0], START + 1); else pass_cnt++;
        total_cnt++; if (vcount !== 32) $display("FAIL single_valid_cnt: got %0d expected 32", vcount); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd1) $display("FAIL single_burst_cnt: got %0d expected 1", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (sb.size() !== 0) $display("FAIL single_sb_left: got %0d expected 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ok;
        clear_rec();
        push_burst(4'd2, 32);
        push_burst(4'd1, 32);
        push_burst(4'd0, 32);
        next_line();
        ok = (runs.size() == 3) ? 1 : 0;
        foreach (runs[i]) if (runs[i] != 32) ok = 0;
        total_cnt++; if (ok != 1) $display("FAIL b2b_runs: got %0d runs expected 3 of 32", runs.size()); else pass_cnt++;
        ok = (gaps.size() == 2) ? 1 : 0;
        foreach (gaps[i]) if (gaps[i] != 4) ok = 0;
        total_cnt++; if (ok != 1) $display("FAIL b2b_gaps: got %0d gaps expected 2 of 4", gaps.size()); else pass_cnt++;
        total_cnt++; if (rise_h[1] - rise_h[0] !== 36) $display("FAIL b2b_period: got %0d expected 36", rise_h[1] - rise_h[0]); else pass_cnt++;
        ok = (bc_hist.size() == 4) ? 1 : 0;
        foreach (bc_hist[i]) if (bc_hist[i] != 4'(i)) ok = 0;
        total_cnt++; if (ok != 1) $display("FAIL b2b_cnt_seq: got %0d steps expected 0,1,2,3", bc_hist.size()); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd3) $display("FAIL b2b_burst_cnt: got %0d expected 3", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (vcount !== 96) $display("FAIL b2b_valid_cnt: got %0d expected 96", vcount); else pass_cnt++;
    endtask

    task automatic test_underrun();
        clear_rec();
        push_burst(4'd0, 20);
        next_line();
        total_cnt++; if (runs.size() !== 1 || runs[0] !== 20) $display("FAIL ur_runs: got %0d runs len %0d expected 1 len 20", runs.size(), runs[0]); else pass_cnt++;
        total_cnt++; if (ur_h.size() !== 1) $display("FAIL ur_pulses: got %0d expected 1", ur_h.size()); else pass_cnt++;
        total_cnt++; if (ur_h[0] !== START + 22) $display("FAIL ur_time: got %0d expected %0d", ur_h[0], START + 22); else pass_cnt++;
        total_cnt++; if (rd_empty_cnt !== 0) $display("FAIL ur_rd_while_empty: got %0d expected 0", rd_empty_cnt); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd0) $display("FAIL ur_burst_cnt: got %0d expected 0", o_burst_cnt); else pass_cnt++;
        clear_rec();
        push_burst(4'd0, 32);
        next_line();
        total_cnt++; if (runs.size() !== 1 || runs[0] !== 32) $display("FAIL ur_resume: got %0d runs len %0d expected 1 len 32", runs.size(), runs[0]); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd1) $display("FAIL ur_resume_cnt: got %0d expected 1", o_burst_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        clear_rec();
        push_burst(4'd0, 32);
        wait_run(10);
        i_rst_n = 1'b0;
        #1;
        total_cnt++; if (o_rd_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %0b expected 0", o_rd_en); else pass_cnt++;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b expected 0", o_valid); else pass_cnt++;
        total_cnt++; if (o_data !== 12'd0) $display("FAIL mid_rst_data: got %h expected 000", o_data); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd0) $display("FAIL mid_rst_burst_cnt: got %0d expected 0", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL mid_rst_audio_on: got %0b expected 0", o_audio_on); else pass_cnt++;
        rd_s = 1'b0;
        valid_prev = 1'b0;
        sb.delete();
        fifo.delete();
        vde_en = 1'b0;
        cycle();
        cycle();
        i_rst_n = 1'b1;
        while (hc != 0) cycle();
        clear_rec();
        push_burst(4'd0, 32);
        next_line();
        total_cnt++; if (runs.size() !== 0) $display("FAIL mid_rst_no_vde: got %0d runs expected 0", runs.size()); else pass_cnt++;
        vde_en = 1'b1;
        clear_rec();
        next_line();
        total_cnt++; if (runs.size() !== 1 || runs[0] !== 32) $display("FAIL mid_rst_resume: got %0d runs len %0d expected 1 len 32", runs.size(), runs[0]); else pass_cnt++;
    endtask

    task automatic test_flush();
        clear_rec();
        push_burst(4'd0, 32);
        wait_run(5);
        i_flush = 1'b1;
        #1;
        total_cnt++; if (o_rd_en !== 1'b0) $display("FAIL flush_rd_gate: got %0b expected 0", o_rd_en); else pass_cnt++;
        rd_s = 1'b0;
        valid_prev = 1'b0;
        sb.delete();
        fifo.delete();
        cycle();
        total_cnt++; if (o_valid !== 1'b0 || o_data !== 12'd0) $display("FAIL flush_outputs: got valid %0b data %h expected 0 000", o_valid, o_data); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd0) $display("FAIL flush_burst_cnt: got %0d expected 0", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL flush_audio_on: got %0b expected 0", o_audio_on); else pass_cnt++;
        while (hc != 0) cycle();
    endtask

    task automatic test_audio();
        clear_rec();
        frame_edge();
        frame_edge();
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL audio_empty_frame: got %0b expected 0", o_audio_on); else pass_cnt++;
        push_burst(4'd0, 32);
        frame_edge();
        total_cnt++; if (o_audio_on !== 1'b1) $display("FAIL audio_data_frame: got %0b expected 1", o_audio_on); else pass_cnt++;
        frame_edge();
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL audio_drop: got %0b expected 0", o_audio_on); else pass_cnt++;
        while (!(hc == H_TOTAL - 1 && vc == V_TOTAL - 1)) cycle();
        glitch = 1'b1;
        cycle();
        glitch = 1'b0;
        cycle();
        total_cnt++; if (o_audio_on !== 1'b0) $display("FAIL audio_boundary_old: got %0b expected 0", o_audio_on); else pass_cnt++;
        frame_edge();
        total_cnt++; if (o_audio_on !== 1'b1) $display("FAIL audio_boundary_new: got %0b expected 1", o_audio_on); else pass_cnt++;
        total_cnt++; if (ao_bad !== 0) $display("FAIL audio_mid_frame_change: got %0d expected 0", ao_bad); else pass_cnt++;
    endtask

    task automatic test_saturate();
        int ok;
        while (hc != 0) cycle();
        clear_rec();
        for (int b = 0; b < 16; b++) push_burst(4'd15, 32);
        next_line();
        ok = (runs.size() == 15) ? 1 : 0;
        foreach (runs[i]) if (runs[i] != 32) ok = 0;
        total_cnt++; if (ok != 1) $display("FAIL sat_runs: got %0d runs expected 15 of 32", runs.size()); else pass_cnt++;
        total_cnt++; if (o_burst_cnt !== 4'd15) $display("FAIL sat_burst_cnt: got %0d expected 15", o_burst_cnt); else pass_cnt++;
        total_cnt++; if (fifo.size() !== 32) $display("FAIL sat_left: got %0d expected 32", fifo.size()); else pass_cnt++;
        total_cnt++; if (vcount !== 480) $display("FAIL sat_valid_cnt: got %0d expected 480", vcount); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_underrun();
        test_reset_mid_burst();
        test_flush();
        test_audio();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
